// File: rtl/traffic_light_controller.sv
// Fixed-time T-junction traffic light controller: a six-phase Moore FSM with
// a per-phase dwell counter driving four one-hot {R,Y,G} lamp groups.
module traffic_light_controller #(
    parameter int unsigned T_MG = 7,
    parameter int unsigned T_Y  = 2,
    parameter int unsigned T_TG = 5,
    parameter int unsigned T_SG = 3
) (
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    input  logic       clk,
    input  logic       rst
);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [7:0] DUR_MG = 8'(T_MG);
    localparam logic [7:0] DUR_Y  = 8'(T_Y);
    localparam logic [7:0] DUR_TG = 8'(T_TG);
    localparam logic [7:0] DUR_SG = 8'(T_SG);

    typedef enum logic [2:0] {
        PH_MG  = 3'd0,
        PH_M2Y = 3'd1,
        PH_TG  = 3'd2,
        PH_MTY = 3'd3,
        PH_SG  = 3'd4,
        PH_SY  = 3'd5
    } phase_t;

    phase_t     phase_q, phase_d;
    logic [7:0] count_q, count_d;
    logic [7:0] last_count;
    logic       phase_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_MG;
            count_q <= 8'd0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    // Last count value of the current phase (duration minus one).
    always_comb begin
        last_count  = 8'd0;
        phase_legal = 1'b1;
        case (phase_q)
            PH_MG:  last_count = DUR_MG - 8'd1;
            PH_M2Y: last_count = DUR_Y  - 8'd1;
            PH_TG:  last_count = DUR_TG - 8'd1;
            PH_MTY: last_count = DUR_Y  - 8'd1;
            PH_SG:  last_count = DUR_SG - 8'd1;
            PH_SY:  last_count = DUR_Y  - 8'd1;
            default: phase_legal = 1'b0;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        count_d = count_q + 8'd1;
        if (!phase_legal) begin
            phase_d = PH_MG;
            count_d = 8'd0;
        end else if (count_q == last_count) begin
            count_d = 8'd0;
            case (phase_q)
                PH_MG:   phase_d = PH_M2Y;
                PH_M2Y:  phase_d = PH_TG;
                PH_TG:   phase_d = PH_MTY;
                PH_MTY:  phase_d = PH_SG;
                PH_SG:   phase_d = PH_SY;
                PH_SY:   phase_d = PH_MG;
                default: phase_d = PH_MG;
            endcase
        end
    end

    // Unlisted encodings fall through to all-red, the safe failure mode.
    always_comb begin
        light_M1 = LAMP_RED;
        light_M2 = LAMP_RED;
        light_MT = LAMP_RED;
        light_S  = LAMP_RED;
        case (phase_q)
            PH_MG: begin
                light_M1 = LAMP_GREEN;
                light_M2 = LAMP_GREEN;
            end
            PH_M2Y: begin
                light_M1 = LAMP_GREEN;
                light_M2 = LAMP_YELLOW;
            end
            PH_TG: begin
                light_M1 = LAMP_GREEN;
                light_MT = LAMP_GREEN;
            end
            PH_MTY: begin
                light_M1 = LAMP_YELLOW;
                light_MT = LAMP_YELLOW;
            end
            PH_SG:   light_S = LAMP_GREEN;
            PH_SY:   light_S = LAMP_YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: default-timed and all-ones-timed
// instances checked against a cycle-count reference model and a vector table.
module tb_traffic_light_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Lamp words packed as {M1, M2, MT, S}.
    localparam logic [11:0] L_MG  = {G, G, R, R};
    localparam logic [11:0] L_M2Y = {G, Y, R, R};
    localparam logic [11:0] L_TG  = {G, R, G, R};
    localparam logic [11:0] L_MTY = {Y, R, Y, R};
    localparam logic [11:0] L_SG  = {R, R, R, G};
    localparam logic [11:0] L_SY  = {R, R, R, Y};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] a_m1, a_m2, a_mt, a_s;
    logic [2:0] b_m1, b_m2, b_mt, b_s;
    logic [11:0] a_l, b_l;

    assign a_l = {a_m1, a_m2, a_mt, a_s};
    assign b_l = {b_m1, b_m2, b_mt, b_s};

    traffic_light_controller dut_a (
        .light_M1(a_m1), .light_M2(a_m2), .light_MT(a_mt), .light_S(a_s),
        .clk(clk), .rst(rst)
    );

    traffic_light_controller #(.T_MG(1), .T_Y(1), .T_TG(1), .T_SG(1)) dut_b (
        .light_M1(b_m1), .light_M2(b_m2), .light_MT(b_mt), .light_S(b_s),
        .clk(clk), .rst(rst)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // rising edges seen with rst low since last reset

    typedef struct {
        string       name;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[22];

    function automatic logic [11:0] phase_lamps(int p);
        case (p)
            0: return L_MG;
            1: return L_M2Y;
            2: return L_TG;
            3: return L_MTY;
            4: return L_SG;
            default: return L_SY;
        endcase
    endfunction

    // Phase = position of (k mod period) within the cumulative durations.
    function automatic logic [11:0] model(int kk, int tmg, int ty, int ttg, int tsg);
        int d[6];
        int r;
        int p;
        d = '{tmg, ty, ttg, ty, tsg, ty};
        r = kk % (tmg + ty + ttg + ty + tsg + ty);
        p = 0;
        while (r >= d[p]) begin
            r -= d[p];
            p++;
        end
        return phase_lamps(p);
    endfunction

    function automatic bit safe(logic [11:0] l);
        bit onehot, main_go, s_go;
        onehot  = $onehot(l[11:9]) && $onehot(l[8:6]) && $onehot(l[5:3]) && $onehot(l[2:0]);
        main_go = !l[11] || !l[8] || !l[5];
        s_go    = !l[2];
        return onehot && !(main_go && s_go) && !(!l[8] && !l[5]);
    endfunction

    task automatic check(string name, logic [11:0] got, logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%b exp=%b", name, k, got, exp);
        end
    endtask

    task automatic check_bit(string name, bit got);
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL %s k=%0d got=%b exp=1", name, k, got);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, "_a"}, a_l, model(k, 7, 2, 5, 3));
        check({tag, "_b"}, b_l, model(k, 1, 1, 1, 1));
        check_bit({tag, "_safe_a"}, safe(a_l));
        check_bit({tag, "_safe_b"}, safe(b_l));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) k++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 7; i++)  vecs[i]  = '{"MG",  L_MG};
        for (int i = 7; i < 9; i++)  vecs[i]  = '{"M2Y", L_M2Y};
        for (int i = 9; i < 14; i++) vecs[i]  = '{"TG",  L_TG};
        for (int i = 14; i < 16; i++) vecs[i] = '{"MTY", L_MTY};
        for (int i = 16; i < 19; i++) vecs[i] = '{"SG",  L_SG};
        for (int i = 19; i < 21; i++) vecs[i] = '{"SY",  L_SY};
        vecs[21] = '{"MG_wrap", L_MG};

        // Asynchronous reset between edges takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("async_reset_a", a_l, L_MG);
        check("async_reset_b", b_l, L_MG);
        step();
        step();
        check_all("reset_hold");

        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 22; i++) begin
            if (i > 0) step();
            check({"vec_", vecs[i].name}, a_l, vecs[i].exp);
            check({"vec_fast_", vecs[i].name}, b_l, model(k, 1, 1, 1, 1));
        end

        // Advance into the middle of SG, then reset asynchronously.
        repeat (17) step();
        check("pre_reset_SG", a_l, L_SG);
        #2 rst = 1'b1;
        k = 0;
        #1;
        check("mid_reset_a", a_l, L_MG);
        check("mid_reset_b", b_l, L_MG);
        step();
        check_all("mid_reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            check("post_reset_MG", a_l, L_MG);
        end
        step();
        check("post_reset_M2Y", a_l, L_M2Y);

        // Long randomized run with sporadic asynchronous resets.
        rst = 1'b1;
        k = 0;
        step();
        rst = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            check_all("run");
            if ($urandom_range(0, 39) == 0) begin
                int hold;
                hold = $urandom_range(1, 3);
                #2 rst = 1'b1;
                k = 0;
                #1;
                check_all("rand_reset");
                for (int h = 0; h < hold; h++) begin
                    step();
                    check_all("rand_reset_hold");
                end
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
